// File: rtl/b_feed_pkg.sv
// Shared types and helpers for the B-input feed sequencer.
// Optional parity support is enabled by defining B_FEED_PARITY_EN.
package b_feed_pkg;

   localparam int WORD_W = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Odd parity: the word plus its parity bit must carry an odd number of ones.
   function automatic logic odd_par_ok(input word_t i_word, input logic i_par);
      return ^{i_word, i_par};
   endfunction

endpackage

// File: rtl/b_feed_fifo.sv
// Power-of-two circular FIFO with occupancy count; pointers wrap naturally.
// Push is ignored while full and pop is ignored while empty.
module b_feed_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/b_feed_sequencer.sv
// Buffers 4-bit words and holds each one on B's drive lines for HOLD cycles.
// Define B_FEED_PARITY_EN to add s_par input and sticky par_err output.
module b_feed_sequencer
   import b_feed_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   inout  wire                    VDD,
   inout  wire                    VSS,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [3:0]             s_data,
`ifdef B_FEED_PARITY_EN
   input  logic                   s_par,
   output logic                   par_err,
`endif
   output logic                   drv_one,
   output logic                   drv_two,
   output logic                   drv_three,
   output logic                   drv_four,
   output logic                   drv_valid,
   output logic [$clog2(DEPTH):0] level
);

   localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
`ifdef B_FEED_PARITY_EN
   localparam int FW = WORD_W + 1;
`else
   localparam int FW = WORD_W;
`endif

   // Supply pins exist only for netlist pin compatibility.
   wire w_unused_supply = VDD ^ VSS;

   state_t                  r_state;
   logic [HCW-1:0]          r_hold_cnt;
   word_t                   r_drv;
   logic [FW-1:0]           w_wdata;
   logic [FW-1:0]           w_rdata;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop;
   logic [$clog2(DEPTH):0]  w_level;

`ifdef B_FEED_PARITY_EN
   assign w_wdata = {s_par, s_data};
`else
   assign w_wdata = s_data;
`endif

   b_feed_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (s_valid),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Pop from IDLE, or back-to-back when the current word's hold has expired.
   assign w_pop = !w_empty && ((r_state == ST_IDLE) || (r_hold_cnt == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_drv      <= '0;
      end else if (w_pop) begin
         r_state    <= ST_HOLD;
         r_hold_cnt <= HCW'(HOLD - 1);
         r_drv      <= w_rdata[WORD_W-1:0];
      end else if (r_state == ST_HOLD) begin
         if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HCW'(1);
         end else begin
            r_state <= ST_IDLE;
         end
      end
   end

`ifdef B_FEED_PARITY_EN
   logic r_par_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par_err <= 1'b0;
      end else if (w_pop && !odd_par_ok(w_rdata[WORD_W-1:0], w_rdata[WORD_W])) begin
         r_par_err <= 1'b1;
      end
   end

   assign par_err = r_par_err;
`endif

   assign s_ready   = !w_full;
   assign level     = w_level;
   assign drv_valid = (r_state == ST_HOLD);
   assign drv_one   = r_drv[0];
   assign drv_two   = r_drv[1];
   assign drv_three = r_drv[2];
   assign drv_four  = r_drv[3];

endmodule

// File: tb/tb_b_feed_sequencer.sv
// Bench for b_feed_sequencer: directed vector table, hand sequences and a
// queue-based reference model under random traffic.
module tb_b_feed_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   wire        w_vdd;
   wire        w_vss;
   assign w_vdd = 1'b1;
   assign w_vss = 1'b0;

   logic       s_valid = 1'b0;
   logic [3:0] s_data  = 4'h0;
   logic       s_ready;
   logic       d1_one, d1_two, d1_three, d1_four, d1_valid;
   logic [2:0] d1_level;

   logic       s2_valid = 1'b0;
   logic [3:0] s2_data  = 4'h0;
   logic       s2_ready;
   logic       d2_one, d2_two, d2_three, d2_four, d2_valid;
   logic [2:0] d2_level;

`ifdef B_FEED_PARITY_EN
   logic s_par = 1'b1;
   logic s2_par = 1'b1;
   logic par_err, par_err2;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   b_feed_sequencer #(.DEPTH(4), .HOLD(2)) dut (
      .clk(clk), .rst(rst), .VDD(w_vdd), .VSS(w_vss),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef B_FEED_PARITY_EN
      .s_par(s_par), .par_err(par_err),
`endif
      .drv_one(d1_one), .drv_two(d1_two), .drv_three(d1_three), .drv_four(d1_four),
      .drv_valid(d1_valid), .level(d1_level)
   );

   b_feed_sequencer #(.DEPTH(4), .HOLD(1)) dut2 (
      .clk(clk), .rst(rst), .VDD(w_vdd), .VSS(w_vss),
      .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
`ifdef B_FEED_PARITY_EN
      .s_par(s2_par), .par_err(par_err2),
`endif
      .drv_one(d2_one), .drv_two(d2_two), .drv_three(d2_three), .drv_four(d2_four),
      .drv_valid(d2_valid), .level(d2_level)
   );

   wire [3:0] d1_drv = {d1_four, d1_three, d1_two, d1_one};
   wire [3:0] d2_drv = {d2_four, d2_three, d2_two, d2_one};

   typedef struct {
      bit         rs;
      bit         v;
      logic [3:0] d;
      logic [3:0] e_drv;
      bit         e_dv;
      logic [2:0] e_lvl;
      bit         e_rdy;
   } vec_t;

   vec_t vecs[23];

   // Reference model: a word queue plus the number of cycles the shown word still owes.
   logic [3:0] mq[$];
   int         m_rem;
   logic [3:0] m_drv;

   task automatic model_reset();
      mq.delete();
      m_rem = 0;
      m_drv = 4'h0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] d);
      bit acc;
      acc = v && (mq.size() < 4);
      if (m_rem > 1) m_rem--;
      else if (mq.size() > 0) begin
         m_drv = mq.pop_front();
         m_rem = 2;
      end else m_rem = 0;
      if (acc) mq.push_back(d);
   endtask

   task automatic check(input string name,
                        input logic [3:0] a_drv, input logic [3:0] e_drv,
                        input logic a_dv, input logic e_dv,
                        input logic [2:0] a_lvl, input logic [2:0] e_lvl,
                        input logic a_rdy, input logic e_rdy);
      n_checks++;
      if ({a_drv, a_dv, a_lvl, a_rdy} !== {e_drv, e_dv, e_lvl, e_rdy}) begin
         n_err++;
         $display("FAIL %s: got drv=%h valid=%b level=%0d ready=%b, want drv=%h valid=%b level=%0d ready=%b",
                  name, a_drv, a_dv, a_lvl, a_rdy, e_drv, e_dv, e_lvl, e_rdy);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d);
      s_valid = v;
      s_data  = d;
`ifdef B_FEED_PARITY_EN
      s_par = ~^d;
`endif
   endtask

   task automatic drive2(input logic v, input logic [3:0] d);
      s2_valid = v;
      s2_data  = d;
`ifdef B_FEED_PARITY_EN
      s2_par = ~^d;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 4'h0);
      drive2(1'b0, 4'h0);
      #3;
      check("reset_dut1", d1_drv, 4'h0, d1_valid, 1'b0, d1_level, 3'd0, s_ready, 1'b1);
      check("reset_dut2", d2_drv, 4'h0, d2_valid, 1'b0, d2_level, 3'd0, s2_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      // Single push of 0xA, then an 8-word burst that fills the FIFO and wraps.
      vecs[0]  = '{1, 1, 4'hA, 4'h0, 0, 3'd1, 1};
      vecs[1]  = '{0, 0, 4'h0, 4'hA, 1, 3'd0, 1};
      vecs[2]  = '{0, 0, 4'h0, 4'hA, 1, 3'd0, 1};
      vecs[3]  = '{0, 0, 4'h0, 4'hA, 0, 3'd0, 1};
      vecs[4]  = '{0, 0, 4'h0, 4'hA, 0, 3'd0, 1};
      vecs[5]  = '{1, 1, 4'h1, 4'h0, 0, 3'd1, 1};
      vecs[6]  = '{0, 1, 4'h2, 4'h1, 1, 3'd1, 1};
      vecs[7]  = '{0, 1, 4'h3, 4'h1, 1, 3'd2, 1};
      vecs[8]  = '{0, 1, 4'h4, 4'h2, 1, 3'd2, 1};
      vecs[9]  = '{0, 1, 4'h5, 4'h2, 1, 3'd3, 1};
      vecs[10] = '{0, 1, 4'h6, 4'h3, 1, 3'd3, 1};
      vecs[11] = '{0, 1, 4'h7, 4'h3, 1, 3'd4, 0};
      vecs[12] = '{0, 1, 4'h8, 4'h4, 1, 3'd3, 1};
      vecs[13] = '{0, 1, 4'h8, 4'h4, 1, 3'd4, 0};
      vecs[14] = '{0, 0, 4'h0, 4'h5, 1, 3'd3, 1};
      vecs[15] = '{0, 0, 4'h0, 4'h5, 1, 3'd3, 1};
      vecs[16] = '{0, 0, 4'h0, 4'h6, 1, 3'd2, 1};
      vecs[17] = '{0, 0, 4'h0, 4'h6, 1, 3'd2, 1};
      vecs[18] = '{0, 0, 4'h0, 4'h7, 1, 3'd1, 1};
      vecs[19] = '{0, 0, 4'h0, 4'h7, 1, 3'd1, 1};
      vecs[20] = '{0, 0, 4'h0, 4'h8, 1, 3'd0, 1};
      vecs[21] = '{0, 0, 4'h0, 4'h8, 1, 3'd0, 1};
      vecs[22] = '{0, 0, 4'h0, 4'h8, 0, 3'd0, 1};

      for (int i = 0; i < 23; i++) begin
         if (vecs[i].rs) do_reset();
         @(negedge clk);
         drive(vecs[i].v, vecs[i].d);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), d1_drv, vecs[i].e_drv, d1_valid, vecs[i].e_dv,
               d1_level, vecs[i].e_lvl, s_ready, vecs[i].e_rdy);
      end

      // Asynchronous reset while 0x7 is held with words queued behind it.
      do_reset();
      @(negedge clk); drive(1'b1, 4'h7);
      @(negedge clk); drive(1'b1, 4'h1);
      @(negedge clk); drive(1'b1, 4'h2);
      @(negedge clk); drive(1'b0, 4'h0);
      check("mid_hold_pre", d1_drv, 4'h7, d1_valid, 1'b1, d1_level, 3'd2, s_ready, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_reset", d1_drv, 4'h0, d1_valid, 1'b0, d1_level, 3'd0, s_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 4'h9);
      @(negedge clk); drive(1'b0, 4'h0);
      @(posedge clk); #1;
      check("after_reset_push", d1_drv, 4'h9, d1_valid, 1'b1, d1_level, 3'd0, s_ready, 1'b1);

      // HOLD=1 instance: new word every cycle with no gap in drv_valid.
      do_reset();
      @(negedge clk); drive2(1'b1, 4'h3);
      @(posedge clk); #1;
      check("h1_push3", d2_drv, 4'h0, d2_valid, 1'b0, d2_level, 3'd1, s2_ready, 1'b1);
      @(negedge clk); drive2(1'b1, 4'hC);
      @(posedge clk); #1;
      check("h1_show3", d2_drv, 4'h3, d2_valid, 1'b1, d2_level, 3'd1, s2_ready, 1'b1);
      @(negedge clk); drive2(1'b0, 4'h0);
      @(posedge clk); #1;
      check("h1_showC", d2_drv, 4'hC, d2_valid, 1'b1, d2_level, 3'd0, s2_ready, 1'b1);
      @(posedge clk); #1;
      check("h1_idle", d2_drv, 4'hC, d2_valid, 1'b0, d2_level, 3'd0, s2_ready, 1'b1);

`ifdef B_FEED_PARITY_EN
      // Bad parity on 0x3 flags par_err at its pop; the word is still driven.
      do_reset();
      @(negedge clk); drive(1'b1, 4'h3); s_par = 1'b0;
      @(negedge clk); drive(1'b0, 4'h0);
      n_checks++;
      if (par_err !== 1'b0) begin
         n_err++;
         $display("FAIL par_before_pop: got par_err=%b, want 0", par_err);
      end
      @(posedge clk); #1;
      check("par_word_driven", d1_drv, 4'h3, d1_valid, 1'b1, d1_level, 3'd0, s_ready, 1'b1);
      n_checks++;
      if (par_err !== 1'b1) begin
         n_err++;
         $display("FAIL par_set: got par_err=%b, want 1", par_err);
      end
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (par_err !== 1'b1) begin
         n_err++;
         $display("FAIL par_sticky: got par_err=%b, want 1", par_err);
      end
`endif

      // Random traffic against the reference model, with busy and quiet phases.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         int pct;
         @(negedge clk);
         check($sformatf("rand%0d", c), d1_drv, m_drv, d1_valid, (m_rem > 0),
               d1_level, 3'(mq.size()), s_ready, (mq.size() < 4));
         pct = ((c / 100) % 2 == 0) ? 85 : 30;
         drive(($urandom_range(0, 99) < pct), 4'($urandom_range(0, 15)));
         @(posedge clk);
         model_step(s_valid, s_data);
      end
`ifdef B_FEED_PARITY_EN
      n_checks++;
      if (par_err !== 1'b0) begin
         n_err++;
         $display("FAIL par_clean: got par_err=%b, want 0", par_err);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
